// File: rtl/dmem_arbiter_pkg.sv
// -----------------------------------------------------------------------------
// dmem_arbiter_pkg
// Shared definitions for the data-memory arbiter: owner-state encoding,
// requester port indices and the default memory/hold sizing.
// No ports (package).
// -----------------------------------------------------------------------------
package dmem_arbiter_pkg;

   // Registered owner state: IDLE means round-robin is in force.
   typedef enum logic [1:0] {
      IDLE = 2'd0,
      OWN0 = 2'd1,
      OWN1 = 2'd2
   } state_t;

   // Requester indices (port 0 = CPU data port, port 1 = loader/debug).
   localparam int PORT0 = 0;
   localparam int PORT1 = 1;

   // Default sizing.
   localparam int DEF_ADDR_WORDS = 256;
   localparam int DEF_MAX_HOLD   = 8;

endpackage

// File: rtl/dmem_arbiter_pick.sv
// -----------------------------------------------------------------------------
// rr_pick2
// Combinational two-way round-robin picker. A lone requester always wins;
// on contention the port that was not granted most recently wins.
// Ports:
//   req[1:0]  request vector, bit n = port n
//   last      index of the most recently granted port
//   gnt[1:0]  one-hot (or zero) grant vector
// -----------------------------------------------------------------------------
module rr_pick2
   import dmem_arbiter_pkg::*;
(
   input  logic [1:0] req,
   input  logic       last,
   output logic [1:0] gnt
);

   always_comb begin
      gnt = 2'b00;
      case (req)
         2'b01:   gnt = 2'b01;
         2'b10:   gnt = 2'b10;
         2'b11:   gnt = (last == 1'(PORT1)) ? 2'b01 : 2'b10;
         default: gnt = 2'b00;
      endcase
   end

endmodule

// File: rtl/dmem_arbiter.sv
// -----------------------------------------------------------------------------
// dmem_arbiter
// Shares one single-port word-addressed data memory between the CPU data
// port (port 0) and a loader/debug master (port 1). Grants are zero-wait
// (same cycle as the request), round-robin by default, with an optional
// lock that lets one port keep the memory for bursts of up to MAX_HOLD
// grants while the other port waits. Out-of-range accesses are granted but
// never write, and read back as zero. Read data is registered and returned
// one cycle after the read grant.
// Ports:
//   clk, rst_n                      clock, asynchronous active-low reset
//   pX_req/we/lock/addr/wdata       request side of port X (held until gnt)
//   pX_gnt                          access performed this cycle
//   pX_rvalid, pX_rdata             registered read return, one cycle later
//   mem_wr, mem_addr, mem_din       drive to the memory
//   mem_dout                        combinational read data from the memory
// -----------------------------------------------------------------------------
module dmem_arbiter
   import dmem_arbiter_pkg::*;
#(
   parameter int ADDR_WORDS = DEF_ADDR_WORDS,
   parameter int MAX_HOLD   = DEF_MAX_HOLD
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        p0_req,
   input  logic        p0_we,
   input  logic        p0_lock,
   input  logic [31:0] p0_addr,
   input  logic [31:0] p0_wdata,
   output logic        p0_gnt,
   output logic        p0_rvalid,
   output logic [31:0] p0_rdata,
   input  logic        p1_req,
   input  logic        p1_we,
   input  logic        p1_lock,
   input  logic [31:0] p1_addr,
   input  logic [31:0] p1_wdata,
   output logic        p1_gnt,
   output logic        p1_rvalid,
   output logic [31:0] p1_rdata,
   output logic        mem_wr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_din,
   input  logic [31:0] mem_dout
);

   localparam int                HOLD_W   = $clog2(MAX_HOLD + 1);
   localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD);

   state_t            state, state_nxt;
   logic              last, last_nxt;
   logic [HOLD_W-1:0] hold_cnt, hold_nxt;
   logic [1:0]        rr_gnt, gnt;
   logic              keep0, keep1;
   logic              inrange0, inrange1;
   logic              sel_we, sel_lock, sel_inrange;

   assign inrange0 = (p0_addr < 32'(ADDR_WORDS));
   assign inrange1 = (p1_addr < 32'(ADDR_WORDS));

   rr_pick2 u_pick (
      .req  ({p1_req, p0_req}),
      .last (last),
      .gnt  (rr_gnt)
   );

   // Grant decision. A locked owner keeps the memory until it has used up
   // its hold budget while the other port is waiting; otherwise round-robin.
   // Grants are forced off during reset so no access can leak through.
   always_comb begin
      keep0 = (state == OWN0) && p0_req && p0_lock &&
              ((hold_cnt < HOLD_LIM) || !p1_req);
      keep1 = (state == OWN1) && p1_req && p1_lock &&
              ((hold_cnt < HOLD_LIM) || !p0_req);
      if (!rst_n)     gnt = 2'b00;
      else if (keep0) gnt = 2'b01;
      else if (keep1) gnt = 2'b10;
      else            gnt = rr_gnt;
   end

   assign p0_gnt = gnt[0];
   assign p1_gnt = gnt[1];

   // Memory drive muxed from the granted port; zero when idle.
   always_comb begin
      mem_addr    = '0;
      mem_din     = '0;
      sel_we      = 1'b0;
      sel_lock    = 1'b0;
      sel_inrange = 1'b0;
      if (gnt[0]) begin
         mem_addr    = p0_addr;
         mem_din     = p0_wdata;
         sel_we      = p0_we;
         sel_lock    = p0_lock;
         sel_inrange = inrange0;
      end else if (gnt[1]) begin
         mem_addr    = p1_addr;
         mem_din     = p1_wdata;
         sel_we      = p1_we;
         sel_lock    = p1_lock;
         sel_inrange = inrange1;
      end
      mem_wr = (|gnt) & sel_we & sel_inrange;
   end

   // Next owner state and hold count. The count only grows while the same
   // port keeps being re-granted under lock; a change of owner restarts it.
   always_comb begin
      state_nxt = IDLE;
      hold_nxt  = '0;
      last_nxt  = last;
      if (|gnt) begin
         last_nxt = gnt[1];
         if (sel_lock) begin
            state_nxt = gnt[1] ? OWN1 : OWN0;
            if (state_nxt == state)
               hold_nxt = (hold_cnt < HOLD_LIM) ? hold_cnt + 1'b1 : hold_cnt;
            else
               hold_nxt = HOLD_W'(1);
         end
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= IDLE;
         last     <= 1'b1;
         hold_cnt <= '0;
      end else begin
         state    <= state_nxt;
         last     <= last_nxt;
         hold_cnt <= hold_nxt;
      end
   end

   // Read return: rdata is only updated by a read grant and otherwise holds.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         p0_rvalid <= 1'b0;
         p0_rdata  <= '0;
         p1_rvalid <= 1'b0;
         p1_rdata  <= '0;
      end else begin
         p0_rvalid <= gnt[0] & ~p0_we;
         p1_rvalid <= gnt[1] & ~p1_we;
         if (gnt[0] & ~p0_we) p0_rdata <= inrange0 ? mem_dout : '0;
         if (gnt[1] & ~p1_we) p1_rdata <= inrange1 ? mem_dout : '0;
      end
   end

endmodule

// File: tb/tb_dmem_arbiter.sv
// -----------------------------------------------------------------------------
// tb_dmem_arbiter
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random
// traffic, checked against a behavioural arbitration/memory model.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_dmem_arbiter;

   localparam int AW = 256;
   localparam int MH = 8;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        p0_req, p0_we, p0_lock, p0_gnt, p0_rvalid;
   logic [31:0] p0_addr, p0_wdata, p0_rdata;
   logic        p1_req, p1_we, p1_lock, p1_gnt, p1_rvalid;
   logic [31:0] p1_addr, p1_wdata, p1_rdata;
   logic        mem_wr;
   logic [31:0] mem_addr, mem_din, mem_dout;

   always #5 clk = ~clk;

   dmem_arbiter #(.ADDR_WORDS(AW), .MAX_HOLD(MH)) dut (
      .clk(clk), .rst_n(rst_n),
      .p0_req(p0_req), .p0_we(p0_we), .p0_lock(p0_lock), .p0_addr(p0_addr),
      .p0_wdata(p0_wdata), .p0_gnt(p0_gnt), .p0_rvalid(p0_rvalid), .p0_rdata(p0_rdata),
      .p1_req(p1_req), .p1_we(p1_we), .p1_lock(p1_lock), .p1_addr(p1_addr),
      .p1_wdata(p1_wdata), .p1_gnt(p1_gnt), .p1_rvalid(p1_rvalid), .p1_rdata(p1_rdata),
      .mem_wr(mem_wr), .mem_addr(mem_addr), .mem_din(mem_din), .mem_dout(mem_dout)
   );

   // Attached memory (environment, not the reference).
   logic [31:0] mem [0:AW-1];
   assign mem_dout = (mem_addr < AW) ? mem[mem_addr[7:0]] : 32'hBADC0DE5;
   always @(posedge clk) if (mem_wr) mem[mem_addr[7:0]] <= mem_din;

   // Reference model state.
   logic [31:0] ref_mem [0:AW-1];
   int          m_last, m_owner, m_streak;
   logic [31:0] rq0[$], rq1[$];
   logic [31:0] hold_exp [2];

   // Pending transaction per requester (held until granted).
   bit          pend_req [2], pend_we [2], pend_lock [2];
   logic [31:0] pend_addr [2], pend_wdata [2];

   int total, bad;
   int g_exp;

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s actual=%h required=%h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   task automatic set_port(input int p, input bit we, input bit lk,
                           input logic [31:0] a, input logic [31:0] d);
      pend_req[p] = 1; pend_we[p] = we; pend_lock[p] = lk;
      pend_addr[p] = a; pend_wdata[p] = d;
   endtask

   task automatic drive();
      p0_req = pend_req[0]; p0_we = pend_we[0]; p0_lock = pend_lock[0];
      p0_addr = pend_addr[0]; p0_wdata = pend_wdata[0];
      p1_req = pend_req[1]; p1_we = pend_we[1]; p1_lock = pend_lock[1];
      p1_addr = pend_addr[1]; p1_wdata = pend_wdata[1];
   endtask

   task automatic model_reset();
      m_last = 1; m_owner = -1; m_streak = 0;
      rq0.delete(); rq1.delete();
      hold_exp[0] = 0; hold_exp[1] = 0;
   endtask

   // Who should be served this cycle, and what the memory should see.
   task automatic model_eval();
      int g;
      logic [31:0] a, rd;
      bit inr;
      g = -1;
      if (m_owner >= 0 && pend_req[m_owner] && pend_lock[m_owner] &&
          (m_streak < MH || !pend_req[1 - m_owner]))
         g = m_owner;
      else if (pend_req[0] && pend_req[1]) g = (m_last == 0) ? 1 : 0;
      else if (pend_req[0]) g = 0;
      else if (pend_req[1]) g = 1;

      a   = (g >= 0) ? pend_addr[g] : 32'h0;
      inr = (g >= 0) && (a < AW);
      chk("p0_gnt", {31'b0, p0_gnt}, (g == 0) ? 32'd1 : 32'd0);
      chk("p1_gnt", {31'b0, p1_gnt}, (g == 1) ? 32'd1 : 32'd0);
      chk("mem_wr", {31'b0, mem_wr}, (g >= 0 && pend_we[g] && inr) ? 32'd1 : 32'd0);
      chk("mem_addr", mem_addr, a);
      chk("mem_din", mem_din, (g >= 0) ? pend_wdata[g] : 32'h0);

      if (g >= 0) begin
         if (!pend_we[g]) begin
            rd = inr ? ref_mem[a[7:0]] : 32'h0;
            if (g == 0) rq0.push_back(rd); else rq1.push_back(rd);
         end else if (inr) begin
            ref_mem[a[7:0]] = pend_wdata[g];
         end
         if (pend_lock[g]) begin
            m_streak = (g == m_owner) ? ((m_streak < MH) ? m_streak + 1 : MH) : 1;
            m_owner  = g;
         end else begin
            m_owner = -1; m_streak = 0;
         end
         m_last = g;
         pend_req[g] = 0;
      end else begin
         m_owner = -1; m_streak = 0;
      end
      g_exp = g;
   endtask

   task automatic cycle();
      @(posedge clk); #1;
      drive();
      @(negedge clk);
      model_eval();
   endtask

   task automatic reset_pulse();
      @(posedge clk); #1;
      rst_n = 0;
      pend_req[0] = 0; pend_req[1] = 0;
      drive();
      model_reset();
      @(negedge clk); #1;
      rst_n = 1;
   endtask

   // Read-return monitor, sampled mid-cycle well after the clock edge.
   task automatic mon_port(input int p, input logic rv, input logic [31:0] rd);
      int n;
      logic [31:0] e;
      n = (p == 0) ? rq0.size() : rq1.size();
      if (rv) begin
         if (n == 0) begin
            chk($sformatf("p%0d_rvalid_unexpected", p), 32'd1, 32'd0);
         end else begin
            e = (p == 0) ? rq0.pop_front() : rq1.pop_front();
            hold_exp[p] = e;
            chk($sformatf("p%0d_rdata", p), rd, e);
         end
      end else begin
         chk($sformatf("p%0d_rvalid_missing", p), 32'd0, (n != 0) ? 32'd1 : 32'd0);
         if (n != 0) begin
            if (p == 0) void'(rq0.pop_front()); else void'(rq1.pop_front());
         end
         chk($sformatf("p%0d_rdata_hold", p), rd, hold_exp[p]);
      end
   endtask

   initial begin
      forever begin
         @(posedge clk); #3;
         if (rst_n === 1'b1) begin
            mon_port(0, p0_rvalid, p0_rdata);
            mon_port(1, p1_rvalid, p1_rdata);
         end
      end
   end

   initial begin
      int n0;
      int k;
      logic [1:0] exp3;
      total = 0; bad = 0;
      for (int i = 0; i < AW; i++) begin
         mem[i]     = 32'h1000_0000 + 32'(i * 7);
         ref_mem[i] = 32'h1000_0000 + 32'(i * 7);
      end
      model_reset();

      // Reset state with both ports requesting a write.
      set_port(0, 1, 1, 32'd1, 32'h1111_1111);
      set_port(1, 1, 1, 32'd2, 32'h2222_2222);
      rst_n = 0;
      drive();
      #12;
      chk("rst_p0_gnt", {31'b0, p0_gnt}, 32'd0);
      chk("rst_p1_gnt", {31'b0, p1_gnt}, 32'd0);
      chk("rst_mem_wr", {31'b0, mem_wr}, 32'd0);
      chk("rst_rvalid", {30'b0, p1_rvalid, p0_rvalid}, 32'd0);
      chk("rst_p0_rdata", p0_rdata, 32'd0);
      chk("rst_p1_rdata", p1_rdata, 32'd0);
      pend_req[0] = 0; pend_req[1] = 0;
      drive();
      @(negedge clk); #1;
      rst_n = 1;

      // Write then read back one word on port 0.
      set_port(0, 1, 0, 32'd5, 32'hDEADBEEF);
      cycle();
      chk("t1_wr_gnt", {31'b0, p0_gnt}, 32'd1);
      chk("t1_wr_memwr", {31'b0, mem_wr}, 32'd1);
      set_port(0, 0, 0, 32'd5, 32'h0);
      cycle();
      chk("t1_rd_gnt", {31'b0, p0_gnt}, 32'd1);
      chk("t1_rd_memwr", {31'b0, mem_wr}, 32'd0);
      cycle();
      chk("t1_rvalid", {31'b0, p0_rvalid}, 32'd1);
      chk("t1_rdata", p0_rdata, 32'hDEADBEEF);

      // Continuous contention without lock alternates, port 0 first.
      reset_pulse();
      for (int i = 0; i < 8; i++) begin
         if (!pend_req[0]) set_port(0, 0, 0, 32'(10 + i), 32'h0);
         if (!pend_req[1]) set_port(1, 0, 0, 32'(40 + i), 32'h0);
         cycle();
         chk("t2_order", {30'b0, p1_gnt, p0_gnt}, (i % 2 == 0) ? 32'd1 : 32'd2);
      end
      pend_req[0] = 0; pend_req[1] = 0;
      cycle();

      // Locked 12-word burst on port 1, port 0 arrives at cycle 3.
      reset_pulse();
      k = 0;
      for (int c = 0; c < 13; c++) begin
         if (!pend_req[1] && k < 12) begin
            set_port(1, 1, 1, 32'(k), 32'hA000_0000 + 32'(k));
            k++;
         end
         if (c == 3) set_port(0, 0, 0, 32'd20, 32'h0);
         cycle();
         exp3 = (c == 8) ? 2'b01 : 2'b10;
         chk("t3_seq", {30'b0, p1_gnt, p0_gnt}, {30'b0, exp3});
      end
      cycle();

      // Out-of-range write is granted but suppressed; read returns zero.
      set_port(0, 1, 0, 32'd300, 32'h1234_5678);
      cycle();
      chk("t4_wr_gnt", {31'b0, p0_gnt}, 32'd1);
      chk("t4_wr_memwr", {31'b0, mem_wr}, 32'd0);
      set_port(0, 0, 0, 32'd7, 32'h0);
      cycle();
      set_port(0, 0, 0, 32'd300, 32'h0);
      cycle();
      chk("t4_rd_gnt", {31'b0, p0_gnt}, 32'd1);
      cycle();
      chk("t4_rvalid", {31'b0, p0_rvalid}, 32'd1);
      chk("t4_rdata", p0_rdata, 32'h0);

      // Reset in the middle of a locked port-1 burst.
      for (int i = 0; i < 3; i++) begin
         set_port(1, 0, 1, 32'(50 + i), 32'h0);
         cycle();
      end
      set_port(1, 1, 1, 32'd60, 32'hCAFE_0060);
      @(posedge clk); #1;
      drive();
      #1;
      chk("t5_pre_gnt", {31'b0, p1_gnt}, 32'd1);
      chk("t5_pre_rvalid", {31'b0, p1_rvalid}, 32'd1);
      rst_n = 0;
      #1;
      chk("t5_rst_gnt", {30'b0, p1_gnt, p0_gnt}, 32'd0);
      chk("t5_rst_memwr", {31'b0, mem_wr}, 32'd0);
      chk("t5_rst_rvalid", {31'b0, p1_rvalid}, 32'd0);
      model_reset();
      @(posedge clk); #1;
      pend_req[1] = 0;
      drive();
      @(negedge clk); #1;
      rst_n = 1;
      set_port(0, 0, 0, 32'd60, 32'h0);
      set_port(1, 0, 0, 32'd61, 32'h0);
      cycle();
      chk("t5_first_win", {30'b0, p1_gnt, p0_gnt}, 32'd1);
      cycle();

      // Long locked run with no competitor, then the other port arrives.
      n0 = 0;
      for (int i = 0; i < 20; i++) begin
         set_port(0, 0, 1, 32'(100 + i), 32'h0);
         cycle();
         if (p0_gnt === 1'b1) n0++;
      end
      chk("t6_p0_grants", 32'(n0), 32'd20);
      set_port(0, 0, 1, 32'd120, 32'h0);
      set_port(1, 0, 0, 32'd121, 32'h0);
      cycle();
      chk("t6_p1_served", {30'b0, p1_gnt, p0_gnt}, 32'd2);
      cycle();
      pend_req[0] = 0;
      cycle();

      // Random traffic.
      for (int i = 0; i < 400; i++) begin
         for (int p = 0; p < 2; p++) begin
            if (!pend_req[p] && ($urandom_range(0, 9) < 6))
               set_port(p, 1'($urandom_range(0, 1)), ($urandom_range(0, 9) < 4),
                        32'($urandom_range(0, 299)), $urandom);
         end
         cycle();
      end
      pend_req[0] = 0; pend_req[1] = 0;
      for (int i = 0; i < 3; i++) cycle();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
